mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates a single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) in the multi-cycle NPC.
- Both requesters, and the downstream memory model/bus, use valid/ready request and response channels.
- One transaction is outstanding at a time; the selected requester owns the port from grant until its response handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_ready  in  1  IFU can take response.
- ifu_rdata  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_size  in  2  access length code (0 = byte, 1 = half, 2 = word).
- lsu_resp_valid  out  1  LSU response valid (load data or store ack).
- lsu_resp_ready  in  1  LSU can take response.
- lsu_rdata  out  DATA_W  LSU read data (raw; extension done by LSU).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  address to memory.
- mem_wen  out  1  write enable.
- mem_wdata  out  DATA_W  write data.
- mem_size  out  2  length code.
- mem_resp_valid  in  1  memory response valid.
- mem_resp_ready  out  1  arbiter accepts response.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States: S_IDLE, S_REQ, S_RESP. Registers: state, grant (0 = IFU, 1 = LSU), last_grant (used only with the optional feature).
- Async reset: state = S_IDLE, grant = 0, last_grant = 0. All valid/ready outputs are 0 while in reset and in S_IDLE.
- S_IDLE:
  - If lsu_req_valid, then grant <= LSU and go to S_REQ.
  - Else if ifu_req_valid, then grant <= IFU and go to S_REQ.
  - Else stay. Both valid in the same cycle: LSU wins (fixed priority).
- S_REQ:
  - mem_req_valid = 1.
  - mem_addr/wen/wdata/size are driven combinationally from the granted requester. IFU forces wen = 0 and size = 2.
  - Granted requester's req_ready = mem_req_ready; the other requester's req_ready = 0.
  - On mem_req_valid & mem_req_ready, go to S_RESP.
- S_RESP:
  - Granted requester's resp_valid = mem_resp_valid, and its rdata = mem_rdata.
  - mem_resp_ready = granted requester's resp_ready. The non-granted requester sees resp_valid = 0.
  - On mem_resp_valid & mem_resp_ready, go to S_IDLE.
- Minimum latency: request valid at cycle N gives req_ready no earlier than N+1 and response no earlier than N+2. One idle cycle separates consecutive transactions.
- Requesters must hold valid and payload stable until ready. Dropping valid in S_REQ is a protocol violation; the arbiter keeps the grant and keeps driving mem_req_valid.
- Response backpressure: while the granted requester holds resp_ready = 0, the state remains S_RESP indefinitely.
- Reset mid-transaction returns to S_IDLE immediately and drops all valids. Memory and requesters are reset by the same rst.
- mem_rdata passes through unmodified. Write-only responses deliver mem_rdata as don't-care.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request in S_IDLE, grant goes to the requester that is not last_grant.
  - last_grant updates on each S_REQ to S_RESP transition.
  - A lone requester is always granted.
- MEM_ARB_RR_EN undefined: fixed LSU priority, and last_grant is not implemented.

Test Plan:
- IFU alone, ifu_addr = 0x80000000, memory returns 0x00000413 one cycle after accept.
  -> ifu_req_ready pulses one cycle later; ifu_resp_valid carries 0x00000413; lsu_resp_valid stays 0; back to S_IDLE.
- LSU store addr = 0x80001000, wdata = 0xDEADBEEF, size = 2.
  -> mem_wen = 1, mem_wdata = 0xDEADBEEF, mem_size = 2; ack is routed only to the LSU.
- IFU and LSU assert valid in the same cycle.
  -> Fixed priority: LSU served first, then IFU after one idle cycle.
  -> With MEM_ARB_RR_EN and last_grant = LSU: IFU served first.
- mem_req_ready held at 0 for 5 cycles, then resp_ready held at 0 for 3 cycles after mem_resp_valid.
  -> State holds in S_REQ, then S_RESP; payload stable; exactly one transfer completes.
- rst asserted asynchronously (between clock edges) while in S_RESP.
  -> All valid/ready outputs drop to 0 without waiting for a clock edge; after release, a new IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single memory port arbiter between IFU (read-only) and LSU (read/write)
// Define MEM_ARB_RR_EN to replace fixed LSU priority with round-robin arbitration.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [1:0]        lsu_size,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    state_t state_q, state_d;
    logic   grant_q, grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= GNT_IFU;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Payload follows the grant register; the IFU only ever issues word reads.
    always_comb begin
        mem_addr  = (grant_q == GNT_LSU) ? lsu_addr  : ifu_addr;
        mem_wen   = (grant_q == GNT_LSU) ? lsu_wen   : 1'b0;
        mem_wdata = (grant_q == GNT_LSU) ? lsu_wdata : '0;
        mem_size  = (grant_q == GNT_LSU) ? lsu_size  : 2'd2;
    end

    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d   = last_grant_q;
`endif
        mem_req_valid  = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_resp_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_valid || ifu_req_valid) begin
                    state_d = S_REQ;
`ifdef MEM_ARB_RR_EN
                    if (lsu_req_valid && ifu_req_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = lsu_req_valid;
                    end
`else
                    grant_d = lsu_req_valid;
`endif
                end
            end
            S_REQ: begin
                // Grant is held even if the requester drops valid here.
                mem_req_valid = 1'b1;
                if (grant_q == GNT_LSU) begin
                    lsu_req_ready = mem_req_ready;
                end else begin
                    ifu_req_ready = mem_req_ready;
                end
                if (mem_req_ready) begin
                    state_d = S_RESP;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            S_RESP: begin
                if (grant_q == GNT_LSU) begin
                    lsu_resp_valid = mem_resp_valid;
                    mem_resp_ready = lsu_resp_ready;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    mem_resp_ready = ifu_resp_ready;
                end
                if (mem_resp_valid && mem_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-order model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [1:0]  lsu_size;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    int errors = 0;
    int checks = 0;
    bit model_last = 1'b0;

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
    } txn_t;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_size(lsu_size),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".mem_req_valid"},  32'(mem_req_valid),  32'd0);
        check({tag, ".ifu_req_ready"},  32'(ifu_req_ready),  32'd0);
        check({tag, ".lsu_req_ready"},  32'(lsu_req_ready),  32'd0);
        check({tag, ".ifu_resp_valid"}, 32'(ifu_resp_valid), 32'd0);
        check({tag, ".lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
        check({tag, ".mem_resp_ready"}, 32'(mem_resp_ready), 32'd0);
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0; ifu_resp_ready = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_resp_ready = 1'b0; lsu_addr = '0;
        lsu_wen = 1'b0; lsu_wdata = '0; lsu_size = 2'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    endtask

    function automatic txn_t mk_ifu(input logic [31:0] addr, input logic [31:0] rdata);
        txn_t t;
        t.lsu = 1'b0; t.addr = addr; t.wen = 1'b0; t.wdata = '0; t.size = 2'd2; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t mk_lsu(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                                    input logic [1:0] size, input logic [31:0] rdata);
        txn_t t;
        t.lsu = 1'b1; t.addr = addr; t.wen = wen; t.wdata = wdata; t.size = size; t.rdata = rdata;
        return t;
    endfunction

    // Entered just after a rising edge with the arbiter idle; plays both requesters and the memory.
    task automatic run_scn(input bit use_ifu, input bit use_lsu, input int lsu_off, input txn_t ti, input txn_t tl,
                           input int req_dly, input int resp_dly, input int bp_dly);
        txn_t q[$];
        txn_t cur;
        int   nexp;
        int   ncomp = 0;
        int   mph = 0;
        int   rcnt = 0;
        int   mcnt = 0;
        int   bcnt = 0;
        bit   acc;
        bit   lsu_first;
        logic gr;
        lsu_first = 1'b1;
`ifdef MEM_ARB_RR_EN
        lsu_first = (model_last == 1'b0);
`endif
        if (use_ifu && use_lsu && lsu_off == 0 && lsu_first) begin
            q.push_back(tl); q.push_back(ti);
        end else begin
            if (use_ifu) q.push_back(ti);
            if (use_lsu) q.push_back(tl);
        end
        nexp = q.size();
        cur = ti;
        ifu_addr = ti.addr;
        lsu_addr = tl.addr; lsu_wen = tl.wen; lsu_wdata = tl.wdata; lsu_size = tl.size;
        ifu_req_valid = use_ifu;
        lsu_req_valid = use_lsu && (lsu_off == 0);
        for (int cyc = 0; cyc < 200 && ncomp < nexp; cyc++) begin
            acc = 1'b0;
            @(negedge clk);
            if (cyc == 0) check_quiet("first_cycle");
            if (mph == 0) begin
                if (mem_req_valid && q.size() > 0) begin
                    cur = q[0];
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wen", 32'(mem_wen), 32'(cur.wen));
                    check("mem_size", 32'(mem_size), 32'(cur.size));
                    if (cur.wen) check("mem_wdata", mem_wdata, cur.wdata);
                    check("granted_req_ready", 32'(cur.lsu ? lsu_req_ready : ifu_req_ready), 32'(mem_req_ready));
                    check("other_req_ready", 32'(cur.lsu ? ifu_req_ready : lsu_req_ready), 32'd0);
                    if (mem_req_ready) begin
                        void'(q.pop_front());
                        model_last = cur.lsu;
                        mph = 1;
                        acc = 1'b1;
                    end
                end else if (!mem_req_valid) begin
                    check("ready_without_req", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
                end
            end else if (mph == 1) begin
                gr = cur.lsu ? lsu_resp_ready : ifu_resp_ready;
                check("req_valid_in_resp", 32'(mem_req_valid), 32'd0);
                check("granted_resp_valid", 32'(cur.lsu ? lsu_resp_valid : ifu_resp_valid), 32'(mem_resp_valid));
                check("other_resp_valid", 32'(cur.lsu ? ifu_resp_valid : lsu_resp_valid), 32'd0);
                check("mem_resp_ready", 32'(mem_resp_ready), 32'(gr));
                if (mem_resp_valid) check("rdata", cur.lsu ? lsu_rdata : ifu_rdata, cur.rdata);
                if (mem_resp_valid && gr) begin
                    ncomp++;
                    mph = 2;
                end
            end else begin
                check_quiet("idle_gap");
                mph = 0;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (cur.lsu) lsu_req_valid = 1'b0;
                else ifu_req_valid = 1'b0;
                rcnt = 0; mcnt = 0; bcnt = 0;
            end
            if (use_lsu && lsu_off > 0 && cyc + 1 == lsu_off) lsu_req_valid = 1'b1;
            if (mph == 0) begin
                mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
                if (mem_req_valid) begin
                    mem_req_ready = (rcnt >= req_dly);
                    rcnt++;
                end else begin
                    mem_req_ready = 1'b0;
                end
            end else if (mph == 1) begin
                mem_req_ready = 1'b0;
                mcnt++;
                mem_resp_valid = (mcnt > resp_dly);
                mem_rdata = mem_resp_valid ? cur.rdata : $urandom;
                gr = mem_resp_valid && (bcnt >= bp_dly);
                if (mem_resp_valid) bcnt++;
                if (cur.lsu) begin
                    lsu_resp_ready = gr; ifu_resp_ready = 1'($urandom_range(0, 1));
                end else begin
                    ifu_resp_ready = gr; lsu_resp_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
                ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
            end
        end
        check("completed_txns", 32'(ncomp), 32'(nexp));
        clear_inputs();
    endtask

    task automatic reset_mid();
        bit seen = 1'b0;
        ifu_addr = 32'h8000_0040; ifu_req_valid = 1'b1; mem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ifu_req_ready;
            @(posedge clk); #1;
        end
        check("rst_mid_accept", 32'(seen), 32'd1);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; ifu_resp_ready = 1'b0;
        @(negedge clk);
        check("rst_mid_resp_valid", 32'(ifu_resp_valid), 32'd1);
        #2 rst = 1'b1;
        #1 check_quiet("rst_async");
        clear_inputs();
        model_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("rst_release");
        @(posedge clk); #1;
    endtask

    initial begin
        txn_t ti, tl;
        bit   ui, ul;
        rst = 1'b1;
        clear_inputs();
        #12;
        check_quiet("reset");
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1 check_quiet("reset_with_valids");
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        ti = mk_ifu(32'h8000_0000, 32'h0000_0413);
        tl = mk_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 2'd2, $urandom);
        run_scn(1'b1, 1'b0, 0, ti, tl, 0, 0, 0);
        run_scn(1'b0, 1'b1, 0, ti, tl, 0, 0, 0);
        ti = mk_ifu(32'h8000_0004, $urandom);
        tl = mk_lsu(32'h8000_2000, 1'b0, '0, 2'd1, $urandom);
        run_scn(1'b1, 1'b1, 0, ti, tl, 0, 0, 0);
        run_scn(1'b1, 1'b1, 0, ti, tl, 1, 0, 1);
        ti = mk_ifu(32'h8000_0008, $urandom);
        run_scn(1'b1, 1'b0, 0, ti, tl, 5, 0, 3);
        reset_mid();
        ti = mk_ifu(32'h8000_000C, $urandom);
        run_scn(1'b1, 1'b0, 0, ti, tl, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            ui = 1'($urandom_range(0, 1));
            ul = 1'($urandom_range(0, 1));
            if (!ui && !ul) ui = 1'b1;
            ti = mk_ifu($urandom, $urandom);
            tl = mk_lsu($urandom, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)), $urandom);
            run_scn(ui, ul, $urandom_range(0, 2), ti, tl,
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
